// File: rtl/twos_to_signmag_serial_pkg.sv
// rtl/twos_to_signmag_serial_pkg.sv - shared ALU constants for the serial sign-magnitude converter
package twos_to_signmag_serial_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CONV = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder shared by the ALU serial datapaths
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Y,
  output logic Cout
);

  assign Y    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/twos_to_signmag_serial.sv
// rtl/twos_to_signmag_serial.sv - bit-serial two's-complement to sign-magnitude converter
import twos_to_signmag_serial_pkg::*;

module twos_to_signmag_serial (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  output logic             busy,
  output logic             done,
  output logic             sign,
  output logic [WIDTH-1:0] Y,
  output logic             ovf
);

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-2:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               sgn_r;
  logic               carry;
  logic               fa_sum;
  logic               fa_cout;

  // Negation is invert-plus-one: XOR with the sign inverts, carry seeded with the sign adds one.
  full_adder u_fa (
    .A    (shreg[0] ^ sgn_r),
    .B    (1'b0),
    .Cin  (carry),
    .Y    (fa_sum),
    .Cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
      sgn_r <= 1'b0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sign  <= 1'b0;
      Y     <= '0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= A;
            sgn_r <= A[WIDTH-1];
            carry <= A[WIDTH-1];
            cnt   <= '0;
            state <= CONV;
            busy  <= 1'b1;
          end
        end
        CONV: begin
          carry <= fa_cout;
          acc   <= {fa_sum, acc[WIDTH-2:1]};
          shreg <= {1'b0, shreg[WIDTH-1:1]};
          cnt   <= cnt + 3'd1;
          // The last sum bit bypasses acc and lands directly in the MSB of Y.
          if (cnt == 3'd7) begin
            Y     <= {fa_sum, acc};
            sign  <= sgn_r;
            ovf   <= sgn_r & fa_sum;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// tb/tb_twos_to_signmag_serial.sv - directed bench for twos_to_signmag_serial
module tb_twos_to_signmag_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_in;
  logic       busy;
  logic       done;
  logic       sign;
  logic [7:0] y;
  logic       ovf;

  int n_assert = 0;
  int n_fail   = 0;

  twos_to_signmag_serial dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a_in),
    .busy  (busy),
    .done  (done),
    .sign  (sign),
    .Y     (y),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns the edge count (1..12) at which done is first seen, 0 if never.
  task automatic wait_done(output int k);
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic run_conv(input string tag, input logic [7:0] av,
                          input logic [7:0] ey, input logic es, input logic eo);
    int k;
    start = 1'b1;
    a_in  = av;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a_in  = 8'hA5;
    chk({tag, "_busy"}, busy, 1);
    wait_done(k);
    chk({tag, "_lat"}, k, 8);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_sign"}, sign, es);
    chk({tag, "_ovf"}, ovf, eo);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_lo"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int k;
    int seen;
    logic [7:0] v;
    logic [7:0] ey;

    rst   = 1'b1;
    start = 1'b0;
    a_in  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sign", sign, 0);
    chk("rst_y", y, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;

    run_conv("pos05", 8'h05, 8'h05, 1'b0, 1'b0);
    run_conv("negFB", 8'hFB, 8'h05, 1'b1, 1'b0);
    run_conv("negFF", 8'hFF, 8'h01, 1'b1, 1'b0);
    run_conv("min80", 8'h80, 8'h80, 1'b1, 1'b1);
    run_conv("zero", 8'h00, 8'h00, 1'b0, 1'b0);
    run_conv("max7F", 8'h7F, 8'h7F, 1'b0, 1'b0);

    // start held through CONV/DONE with a different operand
    start = 1'b1;
    a_in  = 8'h90;
    @(posedge clk);
    @(negedge clk);
    a_in = 8'h01;
    wait_done(k);
    chk("hold_lat", k, 8);
    chk("hold_y", y, 8'h70);
    chk("hold_sign", sign, 1);
    @(posedge clk);
    @(negedge clk);
    chk("hold_done_lo", done, 0);
    chk("hold_idle", busy, 0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("hold_next_busy", busy, 1);
    wait_done(k);
    chk("hold_next_lat", k, 8);
    chk("hold_next_y", y, 8'h01);
    chk("hold_next_sign", sign, 0);
    @(posedge clk);
    @(negedge clk);

    // reset at E4 of a conversion
    start = 1'b1;
    a_in  = 8'hC0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_y", y, 0);
    chk("mid_rst_sign", sign, 0);
    chk("mid_rst_ovf", ovf, 0);
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("mid_rst_no_done", seen, 0);
    run_conv("post40", 8'h40, 8'h40, 1'b0, 1'b0);

    // reset and start on the same edge
    rst   = 1'b1;
    start = 1'b1;
    a_in  = 8'h33;
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_start_idle", busy, 0);

    for (int i = 0; i < 256; i++) begin
      v  = i[7:0];
      ey = v[7] ? 8'(8'd0 - v) : v;
      run_conv($sformatf("sweep%02h", v), v, ey, v[7], v == 8'h80);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
